// File: rtl/qfix_pkg.sv
// Shared sign-magnitude fixed-point helpers: FSM state encoding and format
// geometry, common to qmult_seq and the sibling fixed-point units.
package qfix_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Bit index of the sign in an n-bit sign-magnitude word.
  function automatic int qfix_sign_idx(input int n);
    return n - 1;
  endfunction

  // Width of the magnitude field in an n-bit sign-magnitude word.
  function automatic int qfix_mag_width(input int n);
    return n - 1;
  endfunction

endpackage

// File: rtl/qmult_seq.sv
// Sequential shift-and-add sign-magnitude Q-format multiplier, N-clock latency.
// Define QMULT_SEQ_ROUND_EN to round to nearest instead of truncating.
module qmult_seq
  import qfix_pkg::*;
#(
  parameter int Q = 15,
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] i_multiplicand,
  input  logic [N-1:0] i_multiplier,
  input  logic         i_start,
  output logic [N-1:0] o_result,
  output logic         o_complete,
  output logic         o_overflow
);

  localparam int MW = qfix_mag_width(N);
  localparam int SI = qfix_sign_idx(N);
  localparam int AW = 2 * MW;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(MW);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [AW-1:0] mcand_q, mcand_d;
  logic [MW-1:0] mplier_q, mplier_d;
  logic          sign_q, sign_d;
  logic [N-1:0]  result_q, result_d;
  logic          complete_q, complete_d;
  logic          overflow_q, overflow_d;

  logic [MW-1:0] mag_fin;
  logic          ovf_fin;
  logic          ovf_hi;

  assign ovf_hi = |acc_q[AW-1:Q+MW];

`ifdef QMULT_SEQ_ROUND_EN
  logic [MW:0] mag_rnd;
  // A carry out of the rounding increment is reported as overflow.
  assign mag_rnd = {1'b0, acc_q[Q+MW-1:Q]} + {{MW{1'b0}}, acc_q[Q-1]};
  assign mag_fin = mag_rnd[MW-1:0];
  assign ovf_fin = ovf_hi | mag_rnd[MW];
`else
  assign mag_fin = acc_q[Q+MW-1:Q];
  assign ovf_fin = ovf_hi;
`endif

  always_comb begin
    // NOTE: every next-state signal defaults to its register so no path
    // through the case below leaves one unassigned and infers a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    sign_d     = sign_q;
    result_d   = result_q;
    complete_d = complete_q;
    overflow_d = overflow_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          mcand_d    = {{(AW-MW){1'b0}}, i_multiplicand[MW-1:0]};
          mplier_d   = i_multiplier[MW-1:0];
          sign_d     = i_multiplicand[SI] ^ i_multiplier[SI];
          acc_d      = '0;
          cnt_d      = '0;
          complete_d = 1'b0;
          state_d    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q == LAST) begin
          // Zero magnitude always carries a positive sign.
          result_d   = {sign_q & (mag_fin != '0), mag_fin};
          overflow_d = ovf_fin;
          complete_d = 1'b1;
          state_d    = ST_DONE;
        end else begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      sign_q     <= 1'b0;
      result_q   <= '0;
      complete_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      sign_q     <= sign_d;
      result_q   <= result_d;
      complete_q <= complete_d;
      overflow_q <= overflow_d;
    end
  end

  assign o_result   = result_q;
  assign o_complete = complete_q;
  assign o_overflow = overflow_q;

endmodule

// File: doc/qmult_seq.md
QMULT_SEQ -- requirements
Module: qmult_seq

Interface
REQ-001 SHALL have parameter Q, default 15: number of fractional bits.
REQ-002 SHALL have parameter N, default 32: total word width; bit N-1 is the sign, bits N-2:0 are the magnitude (sign-magnitude format).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port i_multiplicand, input, N bits: operand A, sign-magnitude Q-format.
REQ-006 SHALL have port i_multiplier, input, N bits: operand B, sign-magnitude Q-format.
REQ-007 SHALL have port i_start, input, 1 bit: request to start a multiply; sampled on clk.
REQ-008 SHALL have port o_result, output, N bits: registered product, sign-magnitude Q-format.
REQ-009 SHALL have port o_complete, output, 1 bit: high while o_result holds a finished product.
REQ-010 SHALL have port o_overflow, output, 1 bit: the finished product's magnitude exceeded N-1 bits after scaling.

Function
REQ-011 SHALL implement the FSM states IDLE, BUSY and DONE.
REQ-012 SHALL, on an edge in IDLE or DONE with i_start=1, load both operand magnitudes, latch sign = A[N-1] XOR B[N-1], clear the 2N-2-bit accumulator and the bit counter, deassert o_complete and enter BUSY.
REQ-013 SHALL, in BUSY, examine one multiplier magnitude bit per edge, LSB first; add the left-shifted multiplicand to the accumulator when the bit is 1; run N-1 edges in total.
REQ-014 SHALL, on the edge after the last bit: set o_result magnitude = accumulator[Q+N-2:Q]; set o_overflow = OR(accumulator[2N-3:Q+N-1]); set o_complete=1; enter DONE.
REQ-015 SHALL have a latency of exactly N clocks: start accepted at edge k gives o_complete=1 after edge k+N.
REQ-016 SHALL ignore i_start while in BUSY; the operation in flight and its operands are unaffected.
REQ-017 SHALL remain in DONE, holding o_result, o_overflow and o_complete, until i_start restarts it per REQ-012.
REQ-018 SHALL force the o_result sign bit to 0 when the result magnitude is zero (no negative zero).
REQ-019 SHALL, on overflow, set o_result magnitude to the truncated low bits (no saturation) and o_overflow=1.
REQ-020 SHALL have operands that may change freely after the start edge; only the latched copies are used.

Reset
REQ-021 SHALL, while rst=1, immediately force state=IDLE, o_result=0, o_complete=0, o_overflow=0, accumulator=0 and counter=0, regardless of clk.
REQ-022 SHALL abandon any operation in flight on a mid-operation reset; it produces no output. The first start after reset release behaves per REQ-012.

Configuration
REQ-023 SHALL, with macro QMULT_SEQ_ROUND_EN defined, round to nearest: add accumulator bit Q-1 to the extracted magnitude before REQ-014 storage, with any carry out setting o_overflow.
REQ-024 SHALL, without QMULT_SEQ_ROUND_EN, truncate (discard bits Q-1:0); latency is identical in both builds.

Structure
REQ-025 SHALL take the state enumeration encoding (IDLE=0, BUSY=1, DONE=2) and the sign-magnitude helper constants (sign-bit index, magnitude-width function of N) from shared package qfix_pkg, which is also usable by the sibling fixed-point units.
REQ-026 SHALL be a single module; no sub-module is warranted (one adder, one shifter, one counter).

Verification (N=32, Q=23)
REQ-027 SHALL verify basic product: A=0x00C00000 (1.5), B=0x01000000 (2.0), start pulse -> after 32 clocks o_complete=1, o_result=0x01800000, o_overflow=0.
REQ-028 SHALL verify sign handling: A=0x80C00000 (-1.5), B=0x01000000 -> o_result=0x81800000; also A=0x80000000 (-0), B=0x01000000 -> o_result=0x00000000.
REQ-029 SHALL verify overflow: A=B=0x40000000 (128.0) -> o_overflow=1, o_complete=1 after 32 clocks.
REQ-030 SHALL verify start-while-busy: second start with A=B=0 at clock 10 -> ignored, first result 0x01800000 still delivered at clock 32; start from DONE restarts and drops o_complete on that edge.
REQ-031 SHALL verify reset mid-operation: assert rst at clock 15 -> all outputs 0 asynchronously; next start after release gives the correct product at +32 clocks.
REQ-032 SHALL verify rounding: A=0x00000001, B=0x00400000 -> o_result=0x00000000 without QMULT_SEQ_ROUND_EN and 0x00000001 with it.
